// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size/sign codes, FSM
// state type, byte-mask constants and the memory beat payload.
// Optional feature macro: LSU_MISALIGN_EN (word-crossing accesses split in two beats).
package lsu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    // RV32 load/store size and sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte-lane masks for an aligned access of each size
    localparam logic [BE_W-1:0] MASK_B = 4'b0001;
    localparam logic [BE_W-1:0] MASK_H = 4'b0011;
    localparam logic [BE_W-1:0] MASK_W = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ0,
        ST_WAIT0,
        ST_REQ1,
        ST_WAIT1,
        ST_RESP
    } state_e;

    // One memory beat: lane enables plus lane-steered write data
    typedef struct packed {
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } beat_t;

    function automatic logic [BE_W-1:0] size_mask(input logic [2:0] funct3);
        logic [BE_W-1:0] mask;
        case (funct3)
            F3_B, F3_BU: mask = MASK_B;
            F3_H, F3_HU: mask = MASK_H;
            F3_W:        mask = MASK_W;
            default:     mask = MASK_W;
        endcase
        return mask;
    endfunction

    // Encodings that are never legal regardless of alignment
    function automatic logic f3_illegal(input logic we, input logic [2:0] funct3);
        return (we && funct3[2]) || (funct3 == 3'b011) ||
               (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_master_if.sv
// Bus bundle for lsu_master: core request/response side and data-memory side.
//   master modport : the LSU's view (core request in, response out,
//                    memory request out, memory grant/read data in)
//   slave modport  : the environment's view (core and memory model)
interface lsu_master_if #(
    parameter int unsigned ADDR_W = 32
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic              mem_req;
    logic              mem_gnt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU.
//   st_* : store side; produces byte enables and steered write data per beat
//   ld_* : load side; merges beat read data by byte offset and extends it
// With LSU_MISALIGN_EN the second-beat outputs/inputs (beat1, ld_rdata1) exist.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]        st_funct3,
    input  logic [1:0]        st_off,
    input  logic [DATA_W-1:0] st_wdata,
    output beat_t             beat0,
`ifdef LSU_MISALIGN_EN
    output beat_t             beat1,
    input  logic [DATA_W-1:0] ld_rdata1,
`endif
    input  logic [2:0]        ld_funct3,
    input  logic [1:0]        ld_off,
    input  logic [DATA_W-1:0] ld_rdata0,
    output logic [DATA_W-1:0] ld_data
);

    logic [BE_W-1:0]   mask;
    logic [DATA_W-1:0] rd;
`ifdef LSU_MISALIGN_EN
    logic [2*BE_W-1:0]   be_wide;
    logic [2*DATA_W-1:0] wd_wide;
`endif

    // Store steering: shift mask/data up by the byte offset; overflow is beat 1
    always_comb begin
        mask = size_mask(st_funct3);
`ifdef LSU_MISALIGN_EN
        be_wide     = {4'b0000, mask} << st_off;
        wd_wide     = {32'd0, st_wdata} << {st_off, 3'b000};
        beat0.be    = be_wide[BE_W-1:0];
        beat0.wdata = wd_wide[DATA_W-1:0];
        beat1.be    = be_wide[2*BE_W-1:BE_W];
        beat1.wdata = wd_wide[2*DATA_W-1:DATA_W];
`else
        beat0.be    = mask << st_off;
        beat0.wdata = st_wdata << {st_off, 3'b000};
`endif
    end

    // Load merge: second beat supplies the bytes that fell past the word end
    always_comb begin
`ifdef LSU_MISALIGN_EN
        rd = 32'({ld_rdata1, ld_rdata0} >> {ld_off, 3'b000});
`else
        rd = ld_rdata0 >> {ld_off, 3'b000};
`endif
        case (ld_funct3)
            F3_B:    ld_data = {{24{rd[7]}}, rd[7:0]};
            F3_H:    ld_data = {{16{rd[15]}}, rd[15:0]};
            F3_BU:   ld_data = {24'd0, rd[7:0]};
            F3_HU:   ld_data = {16'd0, rd[15:0]};
            default: ld_data = rd;
        endcase
    end

endmodule

// File: rtl/lsu_master.sv
// Load/store unit master: accepts one core load/store at a time, issues one
// (or two, when split) word requests to data memory and returns a one-cycle
// response with extended load data or an error flag.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : lsu_master_if.master (core request/response + memory port)
// Optional feature macro: LSU_MISALIGN_EN -- word-crossing accesses are split
// into two beats; without it misaligned H/W accesses return rsp_err.
module lsu_master
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    lsu_master_if.master bus
);

    state_e            state_q, state_d;
    logic              accept, req_err, misalign;
    beat_t             beat0;
    logic [DATA_W-1:0] ld_data, ld_rdata0;

    logic              we_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;

    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

`ifdef LSU_MISALIGN_EN
    beat_t             beat1, beat1_q;
    logic              split_q;
    logic [DATA_W-1:0] rdata0_q, ld_rdata1;
`else
    logic [BE_W-1:0]   req_mask;
`endif

    lsu_align u_align (
        .st_funct3 (bus.req_funct3),
        .st_off    (bus.req_addr[1:0]),
        .st_wdata  (bus.req_wdata),
        .beat0     (beat0),
`ifdef LSU_MISALIGN_EN
        .beat1     (beat1),
        .ld_rdata1 (ld_rdata1),
`endif
        .ld_funct3 (funct3_q),
        .ld_off    (off_q),
        .ld_rdata0 (ld_rdata0),
        .ld_data   (ld_data)
    );

    // In WAIT1 the first beat comes from the holding register
`ifdef LSU_MISALIGN_EN
    assign ld_rdata0 = (state_q == ST_WAIT1) ? rdata0_q : bus.mem_rdata;
    assign ld_rdata1 = (state_q == ST_WAIT1) ? bus.mem_rdata : '0;
`else
    assign ld_rdata0 = bus.mem_rdata;
`endif

    // req_ready_q is high exactly in IDLE, so accept implies IDLE
    assign accept = bus.req_valid && req_ready_q;

    // Legality of the incoming request
    always_comb begin
`ifdef LSU_MISALIGN_EN
        misalign = 1'b0;
`else
        req_mask = size_mask(bus.req_funct3);
        misalign = ((req_mask == MASK_H) && bus.req_addr[0]) ||
                   ((req_mask == MASK_W) && (bus.req_addr[1:0] != 2'b00));
`endif
        req_err = f3_illegal(bus.req_we, bus.req_funct3) || misalign;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state and next values of the registered outputs
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_d   = ST_RESP;
                        rsp_err_d = 1'b1;
                    end else begin
                        state_d     = ST_REQ0;
                        mem_addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
                        mem_be_d    = beat0.be;
                        mem_wdata_d = beat0.wdata;
                        mem_we_d    = bus.req_we;
                    end
                end
            end
            ST_REQ0: begin
                if (bus.mem_gnt) state_d = ST_WAIT0;
            end
            ST_WAIT0: begin
                if (bus.mem_rvalid) begin
`ifdef LSU_MISALIGN_EN
                    if (split_q) begin
                        state_d     = ST_REQ1;
                        mem_addr_d  = mem_addr_q + ADDR_W'(4);
                        mem_be_d    = beat1_q.be;
                        mem_wdata_d = beat1_q.wdata;
                    end else
`endif
                    begin
                        state_d     = ST_RESP;
                        rsp_rdata_d = we_q ? '0 : ld_data;
                    end
                end
            end
`ifdef LSU_MISALIGN_EN
            ST_REQ1: begin
                if (bus.mem_gnt) state_d = ST_WAIT1;
            end
            ST_WAIT1: begin
                if (bus.mem_rvalid) begin
                    state_d     = ST_RESP;
                    rsp_rdata_d = we_q ? '0 : ld_data;
                end
            end
`endif
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        mem_req_d   = (state_d == ST_REQ0) || (state_d == ST_REQ1);
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    // Output registers; async reset drops mem_req immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Request context captured on accept; first read beat held for the merge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            funct3_q <= '0;
            off_q    <= '0;
`ifdef LSU_MISALIGN_EN
            split_q  <= 1'b0;
            beat1_q  <= '0;
            rdata0_q <= '0;
`endif
        end else begin
            if (accept) begin
                we_q     <= bus.req_we;
                funct3_q <= bus.req_funct3;
                off_q    <= bus.req_addr[1:0];
`ifdef LSU_MISALIGN_EN
                split_q  <= |beat1.be;
                beat1_q  <= beat1;
`endif
            end
`ifdef LSU_MISALIGN_EN
            if (state_q == ST_WAIT0 && bus.mem_rvalid) rdata0_q <= bus.mem_rdata;
`endif
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule
